cga_vram_arbiter: RTL
=====================

# cga_vram_arbiter

Single-port video SRAM arbiter between the CPU side (ISA memory cycles in the CGA framebuffer window) and the display side (sequencer-timed pixel/character/attribute fetches). It sits between the CGA top level and the external 8-bit SRAM: it drives `ram_a`/`ram_we_l`, returns CPU read data on `isa_dout`, and returns fetched bytes to the pixel pusher on `pixel_data`. Display fetches always win. CPU accesses run only in sequencer-granted slots and hold `isa_rdy` low until they complete.

## Interface
Parameters:
- `ADDR_W`, 19: SRAM address width.
- `RD_LAT`, 1: SRAM read latency, in clocks, from `ram_a` valid to `ram_d` sampled. Legal values are 1 and 2.

Ports:
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst_l` in 1: asynchronous, active-low reset.
- `isa_addr` in ADDR_W: CPU byte address, already offset into the framebuffer.
- `isa_din` in 8: CPU write data.
- `isa_dout` out 8: CPU read data; holds the last read value.
- `isa_read` in 1: level, synchronised CPU read request.
- `isa_write` in 1: level, synchronised CPU write request.
- `isa_rdy` out 1: 0 = CPU must wait.
- `isa_op_enable` in 1: sequencer slot marker; a CPU access may start this cycle.
- `pixel_addr` in ADDR_W: display fetch address.
- `pixel_read` in 1: display fetch strobe, one cycle wide.
- `pixel_data` out 8: fetched display byte.
- `ram_a` out ADDR_W: registered SRAM address.
- `ram_d` in 8: SRAM read data.
- `ram_dout` out 8: SRAM write data.
- `ram_we_l` out 1: SRAM write strobe, active low.
- `ram_oe_l` out 1: SRAM output enable, active low.

## Operation
- Reset values: `ram_a` = 0, `ram_dout` = 0, `ram_we_l` = 1, `ram_oe_l` = 0, `isa_dout` = 0, `pixel_data` = 0, `isa_rdy` = 1; the FSM is in IDLE.
- FSM states are IDLE, RD_WAIT, WR_SETUP, WR_PULSE and DONE.
- IDLE:
  - If `pixel_read` = 1: register `ram_a` ← `pixel_addr`.
  - Otherwise, if a request is pending and `isa_op_enable` = 1: register `ram_a` ← `isa_addr`. A write request goes to WR_SETUP; a read request goes to RD_WAIT.
- Pending request: `isa_read | isa_write` is high and the DONE latch is clear.
  - If `isa_read` and `isa_write` are both high, the request is treated as a write.
- RD_WAIT counts RD_LAT cycles, then captures `ram_d` into `isa_dout` and goes to DONE.
- WR_SETUP:
  - `ram_dout` ← `isa_din` and `ram_oe_l` ← 1; address is stable.
  - Next state is WR_PULSE.
- WR_PULSE: `ram_we_l` = 0 for exactly 1 cycle, then DONE. On that transition `ram_we_l` ← 1 while `ram_a`, `ram_dout` and `ram_oe_l` = 1 are held for one more cycle (hold time); `ram_oe_l` returns to 0 in DONE.
- DONE: `isa_rdy` = 1. The FSM stays here until `isa_read` and `isa_write` are both low, then returns to IDLE. Each CPU strobe therefore causes exactly one SRAM access.
- Display pipeline:
  - The pipeline runs independently of the FSM state.
  - A `pixel_read` asserted while a CPU access is in progress is an integration error. It is legal only with the configuration macro below.
- `isa_rdy`: 0 from the first cycle a request is pending until DONE is entered; 1 otherwise.

## Timing
- Display fetch: `pixel_read` high at edge N → `ram_a` = `pixel_addr` after edge N → `pixel_data` valid after edge N+RD_LAT+1. It stays valid until the next fetch completes.
- CPU read (RD_LAT = 1): slot at edge S → `ram_a` after S → `isa_dout` after S+2 → `isa_rdy` = 1 after S+2.
- CPU write: slot at S → `ram_we_l` low during the cycle after S+1 → `isa_rdy` = 1 after S+2.
- Minimum CPU wait = RD_LAT+1 cycles after the slot. Maximum wait = one full sequencer period plus that.
- Asynchronous reset asserted mid-write: `ram_we_l` goes to 1 immediately, with no partial second pulse. The FSM goes to IDLE.
- If `rst_l` deasserts while a request is held, the request is serviced at the next slot.

## Configuration
- `CGA_SNOW_EN` defined:
  - CPU accesses ignore `isa_op_enable` and start at the first IDLE cycle with `pixel_read` = 0.
  - If `pixel_read` arrives while a CPU access owns `ram_a`, the display capture takes the CPU's byte: the `isa_din` value on a write, or the byte read on a read. This reproduces original CGA snow.
  - The display fetch is not retried.
- `CGA_SNOW_EN` undefined: slot-gated behaviour as described above, with no corruption.

## Test plan
- Reset: hold `rst_l` = 0 → `ram_we_l` = 1, `isa_rdy` = 1, `pixel_data` = 0x00. Release it, then `pixel_read` at `pixel_addr` 0x00010 with SRAM model byte 0xA5 → `pixel_data` = 0xA5 two cycles later (RD_LAT = 1).
- CPU write: `isa_write`, `isa_addr` 0x01234, `isa_din` 0x5A, slot at edge 10 → exactly one `ram_we_l` low cycle with `ram_a` = 0x01234 and `ram_dout` = 0x5A; `isa_rdy` = 1 after edge 12. Holding `isa_write` for 20 more cycles produces no second pulse.
- CPU read waiting for a slot: `isa_read` at 0x00002 (SRAM byte 0x3C), no `isa_op_enable` for 15 cycles → `isa_rdy` = 0 throughout. When the slot arrives, `isa_dout` = 0x3C and `isa_rdy` = 1 two cycles later.
- Priority: `pixel_read` and `isa_op_enable` both high in the same cycle with a request pending → `ram_a` = `pixel_addr`. The CPU access waits for the next slot.
- Reset mid-write: drop `rst_l` during WR_PULSE → `ram_we_l` = 1 in the same cycle; the SRAM model records no corrupted second write.
- With `CGA_SNOW_EN`: CPU write of 0xEE at 0x00400 and `pixel_read` one cycle later at 0x00800 (SRAM byte 0x11) → `pixel_data` = 0xEE. Without the macro the same stimulus gives 0x11, and the write completes at a later slot.

Source files
------------

// File: rtl/cga_vram_arbiter.sv
// CGA video SRAM arbiter: display fetches always win; CPU accesses run in sequencer slots.
// Optional feature: define CGA_SNOW_EN for unslotted CPU access with display corruption ("snow").
module cga_vram_arbiter #(
    parameter int ADDR_W = 19,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic [ADDR_W-1:0] isa_addr,
    input  logic [7:0]        isa_din,
    output logic [7:0]        isa_dout,
    input  logic              isa_read,
    input  logic              isa_write,
    output logic              isa_rdy,
    input  logic              isa_op_enable,
    input  logic [ADDR_W-1:0] pixel_addr,
    input  logic              pixel_read,
    output logic [7:0]        pixel_data,
    output logic [ADDR_W-1:0] ram_a,
    input  logic [7:0]        ram_d,
    output logic [7:0]        ram_dout,
    output logic              ram_we_l,
    output logic              ram_oe_l
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_SETUP,
        WR_PULSE,
        DONE
    } state_t;

    localparam logic [1:0] RD_LAST = 2'(RD_LAT);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_we_l_q, ram_we_l_d;
    logic              ram_oe_l_q, ram_oe_l_d;
    logic [7:0]        isa_dout_q, isa_dout_d;
    logic [7:0]        pixel_data_q, pixel_data_d;
    logic [1:0]        rd_cnt_q, rd_cnt_d;
    logic              cpu_wr_q, cpu_wr_d;
    logic [RD_LAT:0]   pix_vld_q, pix_vld_d;
    logic [RD_LAT:0]   pix_snow_q, pix_snow_d;
    logic [7:0]        snow_byte_q, snow_byte_d;

    logic cpu_req;
    logic cpu_start;
    logic snow_hit;

    // Being in DONE is what marks the current strobe as already serviced.
    assign cpu_req = isa_read | isa_write;

`ifdef CGA_SNOW_EN
    assign cpu_start = cpu_req;
    assign snow_hit  = pixel_read && (state_q != IDLE);
`else
    assign cpu_start = cpu_req && isa_op_enable;
    assign snow_hit  = 1'b0;
`endif

    assign isa_rdy = (state_q == DONE) || ((state_q == IDLE) && !cpu_req);

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch can leave a latch behind.
        state_d      = state_q;
        ram_a_d      = ram_a_q;
        ram_dout_d   = ram_dout_q;
        ram_we_l_d   = ram_we_l_q;
        ram_oe_l_d   = ram_oe_l_q;
        isa_dout_d   = isa_dout_q;
        rd_cnt_d     = rd_cnt_q;
        cpu_wr_d     = cpu_wr_q;

        case (state_q)
            IDLE: begin
                if (pixel_read) begin
                    ram_a_d = pixel_addr;
                end else if (cpu_start) begin
                    ram_a_d  = isa_addr;
                    cpu_wr_d = isa_write;
                    if (isa_write) begin
                        // Data and output-disable settle during WR_SETUP, ahead of the strobe.
                        ram_dout_d = isa_din;
                        ram_oe_l_d = 1'b1;
                        state_d    = WR_SETUP;
                    end else begin
                        rd_cnt_d = 2'd0;
                        state_d  = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (rd_cnt_q == RD_LAST) begin
                    isa_dout_d = ram_d;
                    state_d    = DONE;
                end else begin
                    rd_cnt_d = rd_cnt_q + 2'd1;
                end
            end
            WR_SETUP: begin
                ram_we_l_d = 1'b0;
                state_d    = WR_PULSE;
            end
            WR_PULSE: begin
                ram_we_l_d = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                ram_oe_l_d = 1'b0;
                if (!cpu_req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        pix_vld_d    = {pix_vld_q[RD_LAT-1:0], pixel_read};
        pix_snow_d   = {pix_snow_q[RD_LAT-1:0], snow_hit && cpu_wr_q};
        snow_byte_d  = (snow_hit && cpu_wr_q) ? ram_dout_q : snow_byte_q;
        pixel_data_d = pixel_data_q;
        // A fetch colliding with a CPU read simply sees the CPU byte on ram_d.
        if (pix_vld_q[RD_LAT]) begin
            pixel_data_d = pix_snow_q[RD_LAT] ? snow_byte_q : ram_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= IDLE;
            ram_a_q      <= '0;
            ram_dout_q   <= 8'h00;
            ram_we_l_q   <= 1'b1;
            ram_oe_l_q   <= 1'b0;
            isa_dout_q   <= 8'h00;
            pixel_data_q <= 8'h00;
            rd_cnt_q     <= 2'd0;
            cpu_wr_q     <= 1'b0;
            pix_vld_q    <= '0;
            pix_snow_q   <= '0;
            snow_byte_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            ram_a_q      <= ram_a_d;
            ram_dout_q   <= ram_dout_d;
            ram_we_l_q   <= ram_we_l_d;
            ram_oe_l_q   <= ram_oe_l_d;
            isa_dout_q   <= isa_dout_d;
            pixel_data_q <= pixel_data_d;
            rd_cnt_q     <= rd_cnt_d;
            cpu_wr_q     <= cpu_wr_d;
            pix_vld_q    <= pix_vld_d;
            pix_snow_q   <= pix_snow_d;
            snow_byte_q  <= snow_byte_d;
        end
    end

    assign ram_a      = ram_a_q;
    assign ram_dout   = ram_dout_q;
    assign ram_we_l   = ram_we_l_q;
    assign ram_oe_l   = ram_oe_l_q;
    assign isa_dout   = isa_dout_q;
    assign pixel_data = pixel_data_q;

endmodule
